// File: rtl/bht_update_ctrl.sv
// Write-port sequencer for the 2-bit BHT: valid-bit clear sweep, buffered EX feedback, pred_enable.
// Optional statistics counters (upd_count, drop_count) are enabled by defining BHT_CTRL_STATS_EN.
module bht_update_ctrl #(
    parameter int INDEX_WIDTH = 10,
    parameter int FIFO_DEPTH  = 4,
    parameter int FIFO_AW     = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush_req,
    input  logic                   fb_valid,
    input  logic                   fb_take,
    input  logic [31:0]            fb_pc,
    output logic                   fb_ready,
    output logic                   tbl_we,
    output logic                   tbl_clear,
    output logic [INDEX_WIDTH-1:0] tbl_idx,
    output logic [31:0]            tbl_pc,
    output logic                   tbl_take,
    output logic                   pred_enable,
`ifdef BHT_CTRL_STATS_EN
    output logic [31:0]            upd_count,
    output logic [31:0]            drop_count,
`endif
    output logic                   busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
    logic [FIFO_AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]       count_q, count_d;
    logic [32:0]            mem_q [FIFO_DEPTH];
    logic [32:0]            mem_d [FIFO_DEPTH];
    logic [32:0]            head_s;
    logic                   push_s, pop_s, accept_s;
`ifdef BHT_CTRL_STATS_EN
    logic [31:0]            upd_count_q, upd_count_d;
    logic [31:0]            drop_count_q, drop_count_d;
`endif

    assign head_s = mem_q[rd_ptr_q];

    // Next-state, FIFO bookkeeping and output decode from registered state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        mem_d       = mem_q;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        fb_ready    = 1'b0;
        tbl_we      = 1'b0;
        tbl_clear   = 1'b0;
        tbl_idx     = '0;
        tbl_pc      = 32'd0;
        tbl_take    = 1'b0;
        pred_enable = 1'b0;
        busy        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                tbl_we    = 1'b1;
                tbl_clear = 1'b1;
                tbl_idx   = cnt_q;
                busy      = 1'b1;
                fb_ready  = 1'b1;
                cnt_d     = cnt_q + {{(INDEX_WIDTH-1){1'b0}}, 1'b1};
                if (flush_req) begin
                    cnt_d = '0;
                end else if (cnt_q == {INDEX_WIDTH{1'b1}}) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_RUN: begin
                pred_enable = 1'b1;
                fb_ready    = (count_q != (FIFO_AW+1)'(FIFO_DEPTH));
                pop_s       = (count_q != '0);
                busy        = pop_s;
                tbl_we      = pop_s;
                tbl_idx     = head_s[INDEX_WIDTH:1];
                tbl_pc      = pop_s ? head_s[32:1] : 32'd0;
                tbl_take    = pop_s & head_s[0];
                push_s      = fb_valid & fb_ready & ~flush_req;
                if (flush_req) begin
                    // The head on tbl_* is still written this edge; everything else is dropped.
                    state_d  = ST_CLEAR;
                    cnt_d    = '0;
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                    count_d  = '0;
                end else begin
                    if (push_s) begin
                        mem_d[wr_ptr_q] = {fb_pc, fb_take};
                        wr_ptr_d        = wr_ptr_q + FIFO_AW'(1);
                    end else begin
                        wr_ptr_d = wr_ptr_q;
                    end
                    if (pop_s) begin
                        rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
                    end else begin
                        rd_ptr_d = rd_ptr_q;
                    end
                    case ({push_s, pop_s})
                        2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
                        2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
                        default: count_d = count_q;
                    endcase
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign accept_s = fb_valid & fb_ready;

`ifdef BHT_CTRL_STATS_EN
    // Statistics: update writes, and feedback lost to a sweep or a flush.
    always_comb begin
        upd_count_d  = upd_count_q + 32'(tbl_we & ~tbl_clear);
        drop_count_d = drop_count_q;
        if (state_q == ST_CLEAR) begin
            drop_count_d = drop_count_q + 32'(accept_s);
        end else if (state_q == ST_RUN && flush_req) begin
            drop_count_d = drop_count_q + 32'(count_q) - 32'(pop_s) + 32'(accept_s);
        end else begin
            drop_count_d = drop_count_q;
        end
    end

    assign upd_count  = upd_count_q;
    assign drop_count = drop_count_q;
`endif

    // State, sweep counter and FIFO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 33'd0;
            end
`ifdef BHT_CTRL_STATS_EN
            upd_count_q  <= 32'd0;
            drop_count_q <= 32'd0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
`ifdef BHT_CTRL_STATS_EN
            upd_count_q  <= upd_count_d;
            drop_count_q <= drop_count_d;
`endif
        end
    end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Directed bench for bht_update_ctrl with INDEX_WIDTH=4, FIFO_DEPTH=4.
module tb_bht_update_ctrl;

    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush_req;
    logic          fb_valid;
    logic          fb_take;
    logic [31:0]   fb_pc;
    logic          fb_ready;
    logic          tbl_we;
    logic          tbl_clear;
    logic [IW-1:0] tbl_idx;
    logic [31:0]   tbl_pc;
    logic          tbl_take;
    logic          pred_enable;
    logic          busy;
`ifdef BHT_CTRL_STATS_EN
    logic [31:0]   upd_count;
    logic [31:0]   drop_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    bht_update_ctrl #(.INDEX_WIDTH(IW), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (
        .clk(clk), .reset(reset), .flush_req(flush_req),
        .fb_valid(fb_valid), .fb_take(fb_take), .fb_pc(fb_pc), .fb_ready(fb_ready),
        .tbl_we(tbl_we), .tbl_clear(tbl_clear), .tbl_idx(tbl_idx), .tbl_pc(tbl_pc),
        .tbl_take(tbl_take), .pred_enable(pred_enable),
`ifdef BHT_CTRL_STATS_EN
        .upd_count(upd_count), .drop_count(drop_count),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_sweep(input int idx);
        check_val("sweep_we", 32'(tbl_we), 32'd1);
        check_val("sweep_clear", 32'(tbl_clear), 32'd1);
        check_val("sweep_idx", 32'(tbl_idx), 32'(idx));
        check_val("sweep_pc", tbl_pc, 32'd0);
        check_val("sweep_pred", 32'(pred_enable), 32'd0);
        check_val("sweep_busy", 32'(busy), 32'd1);
        check_val("sweep_ready", 32'(fb_ready), 32'd1);
    endtask

    logic [31:0] pcs   [5] = '{32'h0000_0100, 32'h0000_0210, 32'h0000_1237, 32'h8000_00FF, 32'h0000_0A3C};
    logic        takes [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0]  idxs  [5] = '{4'h0, 4'h0, 4'h7, 4'hF, 4'hC};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; flush_req = 1'b0; fb_valid = 1'b0; fb_take = 1'b0; fb_pc = 32'd0;
        tick(); tick();
        check_val("rst_we", 32'(tbl_we), 32'd0);
        check_val("rst_ready", 32'(fb_ready), 32'd0);
        check_val("rst_pred", 32'(pred_enable), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        #1;
        check_val("idle_we", 32'(tbl_we), 32'd0);
        check_val("idle_busy", 32'(busy), 32'd0);
        tick();
        for (int i = 0; i < 16; i++) begin
            check_sweep(i);
            tick();
        end
        check_val("run_pred", 32'(pred_enable), 32'd1);
        check_val("run_busy", 32'(busy), 32'd0);
        check_val("run_we", 32'(tbl_we), 32'd0);
        check_val("run_ready", 32'(fb_ready), 32'd1);

        // Single feedback: visible the cycle after acceptance, busy drops after the write.
        fb_valid = 1'b1; fb_pc = 32'h0000_0A34; fb_take = 1'b1;
        tick();
        fb_valid = 1'b0;
        check_val("one_we", 32'(tbl_we), 32'd1);
        check_val("one_clear", 32'(tbl_clear), 32'd0);
        check_val("one_idx", 32'(tbl_idx), 32'h4);
        check_val("one_pc", tbl_pc, 32'h0000_0A34);
        check_val("one_take", 32'(tbl_take), 32'd1);
        check_val("one_busy", 32'(busy), 32'd1);
        tick();
        check_val("one_busy_after", 32'(busy), 32'd0);
        check_val("one_we_after", 32'(tbl_we), 32'd0);

        // Back-to-back feedback: one write per cycle in arrival order, fb_ready held.
        for (int i = 0; i < 5; i++) begin
            fb_valid = 1'b1; fb_pc = pcs[i]; fb_take = takes[i];
            #1;
            check_val("strm_ready", 32'(fb_ready), 32'd1);
            tick();
            check_val("strm_we", 32'(tbl_we), 32'd1);
            check_val("strm_clear", 32'(tbl_clear), 32'd0);
            check_val("strm_pc", tbl_pc, pcs[i]);
            check_val("strm_idx", 32'(tbl_idx), 32'(idxs[i]));
            check_val("strm_take", 32'(tbl_take), 32'(takes[i]));
        end
        fb_valid = 1'b0;
        tick();
        check_val("strm_idle_we", 32'(tbl_we), 32'd0);
        check_val("strm_idle_busy", 32'(busy), 32'd0);

        // Flush with a head pending and a same-cycle push: head written, push dropped.
        fb_valid = 1'b1; fb_pc = 32'h0000_0555; fb_take = 1'b0;
        tick();
        fb_pc = 32'h0000_0666; fb_take = 1'b1; flush_req = 1'b1;
        #1;
        check_val("fl_head_we", 32'(tbl_we), 32'd1);
        check_val("fl_head_pc", tbl_pc, 32'h0000_0555);
        tick();
        flush_req = 1'b0; fb_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_sweep(i);
            if (i == 3) begin
                fb_valid = 1'b1; fb_pc = 32'h0000_0777; fb_take = 1'b1;
            end else begin
                fb_valid = 1'b0;
            end
            if (i < 9) tick();
        end

        // Flush at sweep index 9 restarts the sweep from 0; feedback here is discarded.
        flush_req = 1'b1; fb_valid = 1'b1; fb_pc = 32'h0000_0888;
        tick();
        flush_req = 1'b0; fb_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check_sweep(i);
            tick();
        end
        check_val("fl2_pred", 32'(pred_enable), 32'd1);
        check_val("fl2_we", 32'(tbl_we), 32'd0);
        check_val("fl2_busy", 32'(busy), 32'd0);
        tick();
        check_val("fl2_no_upd", 32'(tbl_we), 32'd0);
`ifdef BHT_CTRL_STATS_EN
        check_val("upd_count", upd_count, 32'd7);
        check_val("drop_count", drop_count, 32'd3);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
